// File: rtl/pipe_cond_unit.sv
// Execute-stage condition unit: flags register, condition decode, predicated E->M controls.
// Optional saturating performance counters are enabled with `define COND_PERF_CNT_EN.
module pipe_cond_unit #(
  parameter int unsigned FLAG_W      = 4,
  parameter int unsigned FLAG_GROUPS = 2
`ifdef COND_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   validE,
  input  logic                   stallE,
  input  logic                   flushE,
  input  logic [3:0]             CondE,
  input  logic [FLAG_W-1:0]      ALUFlagsE,
  input  logic [FLAG_GROUPS-1:0] FlagWriteE,
  input  logic                   BranchE,
  input  logic                   RegWriteE,
  input  logic                   MemWriteE,
  input  logic                   PCSrcE,
  input  logic                   NoWriteE,
  output logic                   CondExE,
  output logic                   BranchTakenE,
  output logic [FLAG_W-1:0]      FlagsQ,
  output logic                   PCSrcM,
  output logic                   RegWriteM,
  output logic                   MemWriteM
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       CondFailCnt,
  output logic [CNT_W-1:0]       BrTakenCnt
`endif
);

  localparam int unsigned GRP_W = FLAG_W / FLAG_GROUPS;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] wmask;
  logic              pcsrc_q, pcsrc_d;
  logic              regwr_q, regwr_d;
  logic              memwr_q, memwr_d;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              cond_pass;
  logic              live;
  logic              commit;
  cond_e             cond;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
  assign cond   = cond_e'(CondE);

  always_comb begin
    cond_pass = 1'b1;
    unique case (cond)
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = ~flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = ~flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = ~flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = ~flag_v;
      COND_HI: cond_pass = flag_c & ~flag_z;
      COND_LS: cond_pass = ~flag_c | flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_pass = flag_z | (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b1;
      default: cond_pass = 1'b1;
    endcase
  end

  // CondExE ignores stall so the held instruction keeps its verdict; only the
  // edge-side effects and the branch redirect wait for the release cycle.
  assign live         = validE & ~stallE & ~flushE;
  assign CondExE      = validE & ~flushE & cond_pass;
  assign BranchTakenE = BranchE & CondExE & ~stallE;
  assign commit       = live & CondExE;

  always_comb begin
    wmask = '0;
    for (int unsigned g = 0; g < FLAG_GROUPS; g++) begin
      if (FlagWriteE[g]) wmask[g*GRP_W +: GRP_W] = '1;
    end
  end

  always_comb begin
    flags_d = flags_q;
    pcsrc_d = 1'b0;
    regwr_d = 1'b0;
    memwr_d = 1'b0;
    if (commit) begin
      flags_d = (flags_q & ~wmask) | (ALUFlagsE & wmask);
      pcsrc_d = PCSrcE;
      regwr_d = RegWriteE & ~NoWriteE;
      memwr_d = MemWriteE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      pcsrc_q <= 1'b0;
      regwr_q <= 1'b0;
      memwr_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pcsrc_q <= pcsrc_d;
      regwr_q <= regwr_d;
      memwr_q <= memwr_d;
    end
  end

  assign FlagsQ    = flags_q;
  assign PCSrcM    = pcsrc_q;
  assign RegWriteM = regwr_q;
  assign MemWriteM = memwr_q;

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    br_cnt_d   = br_cnt_q;
    if (live & ~CondExE & (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
    if (live & BranchE & CondExE & (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_cnt_q <= '0;
      br_cnt_q   <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      br_cnt_q   <= br_cnt_d;
    end
  end

  assign CondFailCnt = fail_cnt_q;
  assign BrTakenCnt  = br_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_cond_unit.sv
// Scoreboard bench for pipe_cond_unit; counter checks build only with COND_PERF_CNT_EN.
module tb_pipe_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       validE, stallE, flushE;
  logic [3:0] CondE;
  logic [3:0] ALUFlagsE;
  logic [1:0] FlagWriteE;
  logic       BranchE, RegWriteE, MemWriteE, PCSrcE, NoWriteE;
  logic       CondExE, BranchTakenE;
  logic [3:0] FlagsQ;
  logic       PCSrcM, RegWriteM, MemWriteM;
`ifdef COND_PERF_CNT_EN
  logic [3:0] CondFailCnt, BrTakenCnt;
  int unsigned m_fail, m_br;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  m_flags;
  logic [6:0]  sb_q[$];

  pipe_cond_unit #(
    .FLAG_W      (4),
    .FLAG_GROUPS (2)
`ifdef COND_PERF_CNT_EN
    ,
    .CNT_W       (4)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .validE       (validE),
    .stallE       (stallE),
    .flushE       (flushE),
    .CondE        (CondE),
    .ALUFlagsE    (ALUFlagsE),
    .FlagWriteE   (FlagWriteE),
    .BranchE      (BranchE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .PCSrcE       (PCSrcE),
    .NoWriteE     (NoWriteE),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .FlagsQ       (FlagsQ),
    .PCSrcM       (PCSrcM),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM)
`ifdef COND_PERF_CNT_EN
    ,
    .CondFailCnt  (CondFailCnt),
    .BrTakenCnt   (BrTakenCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: f = {N,Z,C,V}
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Drive one E-stage cycle, check combinational outputs, then check the edge result.
  task automatic step(input logic v, input logic s, input logic f, input logic [3:0] c,
                      input logic [3:0] alu, input logic [1:0] fw, input logic br,
                      input logic rw, input logic mw, input logic pc, input logic nw);
    logic       pass, live, ok;
    logic [3:0] nf;
    logic [6:0] got;
    validE = v; stallE = s; flushE = f; CondE = c; ALUFlagsE = alu; FlagWriteE = fw;
    BranchE = br; RegWriteE = rw; MemWriteE = mw; PCSrcE = pc; NoWriteE = nw;
    #1;
    pass = v && !f && ref_cond(c, m_flags);
    live = v && !s && !f;
    ok   = live && pass;
    check("CondExE", {31'b0, CondExE}, {31'b0, pass});
    check("BranchTakenE", {31'b0, BranchTakenE}, {31'b0, br && pass && !s});
    nf = m_flags;
    if (ok && fw[0]) nf[1:0] = alu[1:0];
    if (ok && fw[1]) nf[3:2] = alu[3:2];
    sb_q.push_back({ok && pc, ok && rw && !nw, ok && mw, nf});
`ifdef COND_PERF_CNT_EN
    if (live && !pass && m_fail < 15) m_fail++;
    if (live && br && pass && m_br < 15) m_br++;
`endif
    @(posedge clk);
    #1;
    m_flags = nf;
    got = {PCSrcM, RegWriteM, MemWriteM, FlagsQ};
    if (sb_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else check("M_and_flags", {25'b0, got}, {25'b0, sb_q.pop_front()});
  endtask

  initial begin
    reset = 1'b0;
    validE = 0; stallE = 0; flushE = 0; CondE = '0; ALUFlagsE = '0; FlagWriteE = '0;
    BranchE = 0; RegWriteE = 0; MemWriteE = 0; PCSrcE = 0; NoWriteE = 0;
    m_flags = '0;
`ifdef COND_PERF_CNT_EN
    m_fail = 0; m_br = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {28'b0, FlagsQ}, 32'd0);
    check("rst_M", {29'b0, PCSrcM, RegWriteM, MemWriteM}, 32'd0);
    reset = 1'b1;

    // Unconditional flag load: Z set
    step(1, 0, 0, 4'd14, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
    check("t1_flags", {28'b0, FlagsQ}, 32'h4);
    // EQ passes, NE fails and leaves flags alone
    step(1, 0, 0, 4'd0, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    check("t2_eq_regw", {31'b0, RegWriteM}, 32'd1);
    step(1, 0, 0, 4'd1, 4'b1111, 2'b11, 0, 1, 0, 0, 0);
    check("t2_ne_regw", {31'b0, RegWriteM}, 32'd0);
    check("t2_ne_flags", {28'b0, FlagsQ}, 32'h4);
    // Partial group write: only {C,V} cleared
    step(1, 0, 0, 4'd14, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4'd14, 4'b0000, 2'b01, 0, 0, 0, 0, 0);
    check("t3_flags", {28'b0, FlagsQ}, 32'hC);
    // Stalled taken branch: two held cycles, then release
    step(1, 1, 0, 4'd14, 4'b0000, 2'b00, 1, 0, 0, 1, 0);
    check("t4_pcsrc_stall0", {31'b0, PCSrcM}, 32'd0);
    step(1, 1, 0, 4'd14, 4'b0000, 2'b00, 1, 0, 0, 1, 0);
    step(1, 0, 0, 4'd14, 4'b0000, 2'b00, 1, 0, 0, 1, 0);
    check("t4_pcsrc_rel", {31'b0, PCSrcM}, 32'd1);
    // Flush beats stall
    step(1, 1, 1, 4'd14, 4'b0011, 2'b11, 0, 0, 1, 0, 0);
    check("t5_memw", {31'b0, MemWriteM}, 32'd0);
    check("t5_flags", {28'b0, FlagsQ}, 32'hC);
    // Compare-type suppresses register write; MemWrite passes
    step(1, 0, 0, 4'd14, 4'b0000, 2'b00, 0, 1, 1, 0, 1);
    step(0, 0, 0, 4'd14, 4'b1010, 2'b11, 1, 1, 1, 1, 0);

    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset mid-cycle while RegWriteM is high and a stall is pending
    step(1, 0, 0, 4'd14, 4'b1111, 2'b11, 0, 1, 0, 0, 0);
    check("t6_pre_regw", {31'b0, RegWriteM}, 32'd1);
    validE = 1; stallE = 1; CondE = 4'd14; FlagWriteE = 2'b11; RegWriteE = 1;
    #2;
    reset = 1'b0;
    #1;
    check("t6_regw", {31'b0, RegWriteM}, 32'd0);
    check("t6_flags", {28'b0, FlagsQ}, 32'd0);
    m_flags = '0;
`ifdef COND_PERF_CNT_EN
    check("t6_cnt", {24'b0, CondFailCnt, BrTakenCnt}, 32'd0);
    m_fail = 0; m_br = 0;
`endif
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_held_dropped", {25'b0, PCSrcM, RegWriteM, MemWriteM, FlagsQ}, 32'd0);

    // Three failed-condition instructions (Z=0 so EQ fails)
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd0, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
`ifdef COND_PERF_CNT_EN
    check("cnt_fail3", {28'b0, CondFailCnt}, 32'd3);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 4'd0, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    check("cnt_fail_sat", {28'b0, CondFailCnt}, 32'd15);
    check("cnt_fail_model", {28'b0, CondFailCnt}, m_fail);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 4'd14, 4'b0000, 2'b00, 1, 0, 0, 1, 0);
    check("cnt_br_sat", {28'b0, BrTakenCnt}, 32'd15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
